dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles spent in REQ+RSP before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 i_dmem_addr  in  32  byte address from memory stage.
REQ-005 i_dmem_wdata  in  32  store data, right-justified.
REQ-006 i_dmem_wr_type  in  2  store size: 00 SB, 01 SH, 10 SW, 11 treated as SW.
REQ-007 i_dmem_rd_type  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, others treated as LW.
REQ-008 i_dmem_wr_en / i_dmem_rd_en  in  1 each  store / load request.
REQ-009 o_dmem_rdata  out  32  extended load result, registered.
REQ-010 o_stall  out  1  freeze pipeline while an access is outstanding.
REQ-011 o_misaligned  out  1  one-cycle pulse for a misaligned access.
REQ-012 o_bus_err  out  1  one-cycle pulse for an access aborted by timeout.
REQ-013 o_bus_req, o_bus_we  out  1 each  bus request, write strobe.
REQ-014 o_bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 o_bus_wdata  out  32  lane-replicated store data; o_bus_be  out  4  byte enables.
REQ-016 i_bus_gnt  in  1  request accepted; i_bus_rvalid  in  1  response/ack; i_bus_rdata  in  32  read word.

Function
REQ-017 FSM states: IDLE, REQ, RSP, DONE.
REQ-018 IDLE: access = wr_en|rd_en; wr_en takes priority when both are set (treated as a store, read ignored).
REQ-019 Misaligned access: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0.
- o_misaligned=1 for that cycle; no bus request; o_stall=0; o_dmem_rdata<=0; stay in IDLE.
REQ-020 Aligned access in IDLE:
- o_stall=1 combinationally.
- Latch addr, be, wdata, we, rd_type.
- Go to REQ.
REQ-021 REQ: o_bus_req=1 with latched fields stable; go to RSP on i_bus_gnt; if i_bus_rvalid arrives in the same cycle, go directly to DONE.
REQ-022 RSP: o_bus_req=0; go to DONE on i_bus_rvalid, capturing i_bus_rdata for loads.
REQ-023 o_stall=1 in REQ and RSP; o_stall=0 in DONE. DONE lasts exactly one cycle, then IDLE.
REQ-024 Store encoding:
- SB: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
- SH: be = 0011 or 1100 by addr[1], wdata = {2{wdata[15:0]}}.
- SW: be = 1111.
REQ-025 Load extraction:
- Select byte/half by latched addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- o_dmem_rdata is updated on the cycle entering DONE; stores leave it unchanged.
REQ-026 Timeout:
- 5-bit-or-wider counter cleared on IDLE->REQ, incremented each cycle in REQ/RSP.
- When the count reaches TIMEOUT-1 without completion: go to DONE, o_bus_err=1 for one cycle, o_dmem_rdata<=0.
- A late i_bus_rvalid received in DONE/IDLE is ignored.
REQ-027 i_bus_gnt and i_bus_rvalid are ignored in IDLE and DONE.
REQ-028 Request-to-DONE latency = cycles to gnt + cycles to rvalid; minimum 2 cycles when gnt and rvalid arrive in the same cycle.

Reset
REQ-029 rst=0 asynchronously forces:
- state IDLE, counter 0;
- o_dmem_rdata=0, o_stall=0, o_misaligned=0, o_bus_err=0, o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0.
REQ-030 Reset asserted mid-access abandons it; no retry after release.

Verification
REQ-031 SB addr=0x103 wdata=0xAB, gnt and rvalid same cycle -> be=1000, bus_wdata=0xABABABAB, bus_addr=0x100, o_stall high for 1 cycle.
REQ-032 LB addr=0x201, rdata=0x0000_80FF, gnt after 2 cycles, rvalid 1 cycle later -> o_dmem_rdata=0xFFFFFF80 in DONE; LBU -> 0x00000080; o_stall high 4 cycles.
REQ-033 LW addr=0x202 -> o_misaligned pulse, no o_bus_req, o_stall=0, o_dmem_rdata=0.
REQ-034 LH with gnt but no rvalid, TIMEOUT=16 -> DONE after 16 cycles in REQ/RSP, o_bus_err pulse, rdata=0; late rvalid ignored.
REQ-035 wr_en and rd_en both set, SW addr=0x10 -> single write, o_bus_we=1, be=1111, rdata unchanged.
REQ-036 rst low while in RSP -> all outputs 0 immediately, IDLE on release, no further bus request.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a gnt/rvalid data bus.
// Handles lane replication, byte enables, load extension, misalignment and access timeout.
module dmem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [1:0]  i_dmem_wr_type,
    input  logic [2:0]  i_dmem_rd_type,
    input  logic        i_dmem_wr_en,
    input  logic        i_dmem_rd_en,
    output logic [31:0] o_dmem_rdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);
    localparam int CW = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 5;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          we_reg;
    logic [2:0]    rd_type_reg;
    logic [31:0]   rdata_reg;
    logic          bus_err_reg;

    logic [1:0]    size;
    logic          access, misaligned_acc, aligned_acc;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic          complete, timed_out;
    logic [7:0]    lane_byte [4];
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;

    // size: 0 byte, 1 half, 2 word; a store wins over a simultaneous load
    always_comb begin
        size = 2'd2;
        if (i_dmem_wr_en) begin
            case (i_dmem_wr_type)
                2'b00:   size = 2'd0;
                2'b01:   size = 2'd1;
                default: size = 2'd2;
            endcase
        end else begin
            case (i_dmem_rd_type)
                3'b000, 3'b100: size = 2'd0;
                3'b001, 3'b101: size = 2'd1;
                default:        size = 2'd2;
            endcase
        end
    end

    assign access         = i_dmem_wr_en | i_dmem_rd_en;
    assign misaligned_acc = access && (((size == 2'd1) && i_dmem_addr[0]) ||
                                       ((size == 2'd2) && (i_dmem_addr[1:0] != 2'b00)));
    assign aligned_acc    = access && !misaligned_acc;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = i_dmem_wdata;
        case (size)
            2'd0: begin
                be_calc    = 4'b0001 << i_dmem_addr[1:0];
                wdata_calc = {4{i_dmem_wdata[7:0]}};
            end
            2'd1: begin
                be_calc    = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{i_dmem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Completion in the final counted cycle beats the timeout
    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state_reg)
            IDLE: if (aligned_acc) state_next = REQ;
            REQ: begin
                if (i_bus_gnt && i_bus_rvalid) begin
                    state_next = DONE;
                    complete   = 1'b1;
                end else if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end else if (i_bus_gnt) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (i_bus_rvalid) begin
                    state_next = DONE;
                    complete   = 1'b1;
                end else if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                    timed_out  = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_byte[gi] = i_bus_rdata[8*gi +: 8];
    end

    assign byte_sel = lane_byte[addr_reg[1:0]];
    assign half_sel = addr_reg[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        case (rd_type_reg)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = i_bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            we_reg      <= 1'b0;
            rd_type_reg <= '0;
            rdata_reg   <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bus_err_reg <= timed_out;
            if (state_reg == IDLE && aligned_acc) begin
                cnt_reg     <= '0;
                addr_reg    <= i_dmem_addr;
                wdata_reg   <= wdata_calc;
                be_reg      <= be_calc;
                we_reg      <= i_dmem_wr_en;
                rd_type_reg <= i_dmem_rd_type;
            end else if (state_reg == REQ || state_reg == RSP) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == IDLE && misaligned_acc) begin
                rdata_reg <= '0;
            end else if (timed_out) begin
                rdata_reg <= '0;
            end else if (complete && !we_reg) begin
                rdata_reg <= load_val;
            end
        end
    end

    // Combinational flags are gated by reset so they read 0 while it is held
    assign o_stall      = rst && ((state_reg == IDLE && aligned_acc) ||
                                  state_reg == REQ || state_reg == RSP);
    assign o_misaligned = rst && (state_reg == IDLE) && misaligned_acc;
    assign o_bus_req    = (state_reg == REQ);
    assign o_bus_we     = we_reg;
    assign o_bus_addr   = {addr_reg[31:2], 2'b00};
    assign o_bus_wdata  = wdata_reg;
    assign o_bus_be     = be_reg;
    assign o_dmem_rdata = rdata_reg;
    assign o_bus_err    = bus_err_reg;
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: stores, loads, misalignment, timeout and reset.
// Inputs change 2ns after posedge; outputs are sampled 3ns after posedge.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0]  wr_type;
    logic [2:0]  rd_type;
    logic        wr_en, rd_en;
    logic        stall, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_dmem_addr(dmem_addr), .i_dmem_wdata(dmem_wdata),
        .i_dmem_wr_type(wr_type), .i_dmem_rd_type(rd_type),
        .i_dmem_wr_en(wr_en), .i_dmem_rd_en(rd_en),
        .o_dmem_rdata(dmem_rdata), .o_stall(stall), .o_misaligned(misaligned),
        .o_bus_err(bus_err), .o_bus_req(bus_req), .o_bus_we(bus_we),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
        .i_bus_gnt(bus_gnt), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
    );

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic issue(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] wt, input logic [2:0] rt);
        wr_en = we; rd_en = re; dmem_addr = a; dmem_wdata = wd; wr_type = wt; rd_type = rt;
    endtask

    // Called in REQ; returns the number of stalled cycles before DONE, leaving time in DONE
    task automatic drive_bus(input int gnt_at, input int rv_at, output int cycles);
        cycles = 0;
        for (int c = 0; c < 40; c++) begin
            bus_gnt = (c == gnt_at); bus_rvalid = (c == rv_at);
            #1;
            if (!stall) break;
            cycles++;
            @(posedge clk); #2;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        issue(1'b0, 1'b1, 32'h100, 32'h0, 2'b00, 3'b010);
        #3;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if ({bus_req, bus_we, bus_be, misaligned, bus_err} !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %h want 00", {bus_req, bus_we, bus_be, misaligned, bus_err}); end
        total++; if ({dmem_rdata, bus_addr, bus_wdata} !== 96'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {dmem_rdata, bus_addr, bus_wdata}); end
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        repeat (2) tick;
        rst = 1'b1;
        tick;
        $display("txn reset released");
    endtask

    task automatic test_store_byte;
        issue(1'b1, 1'b0, 32'h103, 32'hAB, 2'b00, 3'b000);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sb_accept_stall: got %b want 1", stall); end
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin bad++; $display("FAIL sb_req_we: got %b%b want 11", bus_req, bus_we); end
        total++; if (bus_addr !== 32'h100) begin bad++; $display("FAIL sb_addr: got %h want 00000100", bus_addr); end
        total++; if (bus_be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", bus_be); end
        total++; if (bus_wdata !== 32'hABABABAB) begin bad++; $display("FAIL sb_wdata: got %h want abababab", bus_wdata); end
        drive_bus(0, 0, n);
        total++; if (n !== 1) begin bad++; $display("FAIL sb_stall_cycles: got %0d want 1", n); end
        total++; if (bus_req !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL sb_done_flags: got %b%b want 00", bus_req, bus_err); end
        total++; if (dmem_rdata !== 32'h0) begin bad++; $display("FAIL sb_rdata_kept: got %h want 00000000", dmem_rdata); end
        tick;
        $display("txn SB addr=103 be=%b wdata=%h", bus_be, bus_wdata);
    endtask

    task automatic test_store_half;
        issue(1'b1, 1'b0, 32'h102, 32'h5555_1234, 2'b01, 3'b000);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        total++; if (bus_be !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", bus_be); end
        total++; if (bus_wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata: got %h want 12341234", bus_wdata); end
        drive_bus(1, 1, n);
        total++; if (n !== 2) begin bad++; $display("FAIL sh_stall_cycles: got %0d want 2", n); end
        tick;
        $display("txn SH addr=102 be=%b", bus_be);
    endtask

    task automatic test_load_byte;
        bus_rdata = 32'h0000_80FF;
        issue(1'b0, 1'b1, 32'h201, 32'h0, 2'b00, 3'b000);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        total++; if (bus_we !== 1'b0 || bus_addr !== 32'h200) begin bad++; $display("FAIL lb_req: got we=%b addr=%h want we=0 addr=00000200", bus_we, bus_addr); end
        drive_bus(2, 3, n);
        total++; if (n !== 4) begin bad++; $display("FAIL lb_stall_cycles: got %0d want 4", n); end
        total++; if (dmem_rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata: got %h want ffffff80", dmem_rdata); end
        tick;
        issue(1'b0, 1'b1, 32'h201, 32'h0, 2'b00, 3'b100);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(2, 3, n);
        total++; if (dmem_rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata: got %h want 00000080", dmem_rdata); end
        tick;
        $display("txn LB/LBU addr=201 last=%h", dmem_rdata);
    endtask

    task automatic test_load_half_word;
        bus_rdata = 32'h8001_7F00;
        issue(1'b0, 1'b1, 32'h202, 32'h0, 2'b00, 3'b001);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, 1, n);
        total++; if (dmem_rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_rdata: got %h want ffff8001", dmem_rdata); end
        tick;
        issue(1'b0, 1'b1, 32'h200, 32'h0, 2'b00, 3'b101);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, 0, n);
        total++; if (dmem_rdata !== 32'h00007F00) begin bad++; $display("FAIL lhu_rdata: got %h want 00007f00", dmem_rdata); end
        tick;
        bus_rdata = 32'hDEADBEEF;
        issue(1'b0, 1'b1, 32'h300, 32'h0, 2'b00, 3'b010);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, 0, n);
        total++; if (dmem_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata: got %h want deadbeef", dmem_rdata); end
        tick;
        $display("txn LH/LHU/LW last=%h", dmem_rdata);
    endtask

    task automatic test_misaligned;
        issue(1'b0, 1'b1, 32'h202, 32'h0, 2'b00, 3'b010);
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", misaligned); end
        total++; if (stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL mis_stall_req: got %b%b want 00", stall, bus_req); end
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        #1;
        total++; if (misaligned !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL mis_after: got %b%b want 00", misaligned, bus_req); end
        total++; if (dmem_rdata !== 32'h0) begin bad++; $display("FAIL mis_rdata: got %h want 00000000", dmem_rdata); end
        tick;
        issue(1'b1, 1'b0, 32'h101, 32'h0, 2'b01, 3'b000);
        #1;
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_sh: got %b want 1", misaligned); end
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL mis_sh_req: got %b want 0", bus_req); end
        $display("txn misaligned LW 202 / SH 101");
    endtask

    task automatic test_timeout;
        bus_rdata = 32'h1234_5678;
        issue(1'b0, 1'b1, 32'h204, 32'h0, 2'b00, 3'b010);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, 0, n);
        tick;
        total++; if (dmem_rdata !== 32'h12345678) begin bad++; $display("FAIL to_preload: got %h want 12345678", dmem_rdata); end
        issue(1'b0, 1'b1, 32'h204, 32'h0, 2'b00, 3'b001);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, -1, n);
        total++; if (n !== 16) begin bad++; $display("FAIL to_cycles: got %0d want 16", n); end
        total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", bus_err); end
        total++; if (dmem_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 00000000", dmem_rdata); end
        bus_rvalid = 1'b1;
        tick;
        #1;
        total++; if (bus_err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL to_after: got %b%b%b want 000", bus_err, stall, bus_req); end
        tick;
        bus_rvalid = 1'b0;
        total++; if (dmem_rdata !== 32'h0) begin bad++; $display("FAIL to_late_rvalid: got %h want 00000000", dmem_rdata); end
        $display("txn LH timeout after %0d cycles", n);
    endtask

    task automatic test_both_en;
        bus_rdata = 32'h0BAD_F00D;
        issue(1'b0, 1'b1, 32'h300, 32'h0, 2'b00, 3'b010);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        drive_bus(0, 0, n);
        tick;
        bus_rdata = 32'h1111_1111;
        issue(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2'b10, 3'b010);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        total++; if (bus_we !== 1'b1 || bus_be !== 4'b1111) begin bad++; $display("FAIL both_we_be: got %b %b want 1 1111", bus_we, bus_be); end
        total++; if (bus_wdata !== 32'hCAFEF00D || bus_addr !== 32'h10) begin bad++; $display("FAIL both_data: got %h@%h want cafef00d@00000010", bus_wdata, bus_addr); end
        drive_bus(1, 1, n);
        total++; if (dmem_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL both_rdata_kept: got %h want 0badf00d", dmem_rdata); end
        tick;
        #1;
        total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL both_single: got %b%b want 00", bus_req, stall); end
        $display("txn SW+LW addr=10 -> single write");
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 1'b1, 32'h40, 32'h0, 2'b00, 3'b010);
        tick;
        issue(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 3'b000);
        bus_gnt = 1'b1;
        tick;
        bus_gnt = 1'b0;
        total++; if (stall !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL rm_in_rsp: got %b%b want 10", stall, bus_req); end
        #1 rst = 1'b0;
        #1;
        total++; if ({stall, bus_req, bus_we, bus_be, misaligned, bus_err} !== 9'h0) begin bad++; $display("FAIL rm_ctrl: got %h want 000", {stall, bus_req, bus_we, bus_be, misaligned, bus_err}); end
        total++; if ({dmem_rdata, bus_addr} !== 64'h0) begin bad++; $display("FAIL rm_data: got %h want 0", {dmem_rdata, bus_addr}); end
        tick;
        rst = 1'b1;
        bus_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            bus_rvalid = 1'b0;
            total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rm_no_retry: cycle %0d got %b%b want 00", i, bus_req, stall); end
        end
        $display("txn reset during RSP");
    endtask

    initial begin
        test_reset;
        test_store_byte;
        test_store_half;
        test_load_byte;
        test_load_half_word;
        test_misaligned;
        test_timeout;
        test_both_en;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
